// File: rtl/square_nbit_seq.sv
// square_nbit_seq
//   Multi-cycle squarer: p = a*a for a W-bit operand, unsigned or
//   two's-complement per transaction. One shift-add step per cycle over
//   W cycles, valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand present on a/sgn
//   in_ready   operand accepted this cycle (IDLE only, gated by rst_n)
//   a          W-bit operand
//   sgn        1 = a is two's-complement, 0 = unsigned
//   out_valid  p holds a completed result
//   out_ready  consumer takes p this cycle
//   p          2W-bit square of the accepted operand
//   busy       high while a transaction is in flight (CALC or DONE)
module square_nbit_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [W-1:0]   opnd;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [2*W-1:0] addend;
  logic [2*W-1:0] acc_next;
  logic           last;

  // Squaring the magnitude gives the same result as squaring the signed
  // value, so the datapath is purely unsigned after the accept edge.
  always_comb begin
    addend   = {{W{1'b0}}, opnd} << cnt;
    acc_next = opnd[cnt] ? (acc + addend) : acc;
    last     = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= (sgn & a[W-1]) ? (~a + W'(1)) : a;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (last) begin
            // The last step's contribution goes straight into p.
            p     <= acc_next;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_square_nbit_seq.sv
module tb_square_nbit_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv4, ir4, s4, ov4, or4, b4;
  logic [3:0] a4;
  logic [7:0] p4;

  logic        iv8, ir8, s8, ov8, or8, b8;
  logic [7:0]  a8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;

  square_nbit_seq #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .sgn(s4),
    .out_valid(ov4), .out_ready(or4), .p(p4), .busy(b4)
  );

  square_nbit_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .sgn(s8),
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(b8)
  );

  // Reference: interpret operand as signed/unsigned integer and square it.
  function automatic longint sq(input longint unsigned av, input bit s, input int w);
    longint v;
    v = (s && av[w-1]) ? (longint'(av) - (longint'(1) << w)) : longint'(av);
    return v * v;
  endfunction

  // Transaction drivers: start and end at a negedge with the DUT idle.
  // lat = cycles from accept edge to first observed out_valid (-1 = timeout),
  // anom = protocol anomalies seen (in_ready/busy while busy, p/out_valid unstable).
  task automatic drive4(input logic [3:0] av, input logic s, input int stall, input bit glitch,
                        output logic [7:0] pr, output int lat, output int anom);
    anom = 0; lat = -1;
    iv4 = 1'b1; a4 = av; s4 = s; or4 = 1'b0;
    if (ir4 !== 1'b1) anom++;
    @(negedge clk);
    iv4 = 1'b0; a4 = 4'($urandom); s4 = 1'($urandom);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (glitch) begin iv4 = 1'($urandom); a4 = 4'($urandom); end
      @(negedge clk);
      if (ov4 === 1'b1) lat = n;
      else if (ir4 !== 1'b0 || b4 !== 1'b1) anom++;
    end
    iv4 = 1'b0;
    pr = p4;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (ov4 !== 1'b1 || p4 !== pr || ir4 !== 1'b0 || b4 !== 1'b1) anom++;
    end
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || b4 !== 1'b0 || p4 !== pr) anom++;
  endtask

  task automatic drive8(input logic [7:0] av, input logic s, input int stall, input bit glitch,
                        output logic [15:0] pr, output int lat, output int anom);
    anom = 0; lat = -1;
    iv8 = 1'b1; a8 = av; s8 = s; or8 = 1'b0;
    if (ir8 !== 1'b1) anom++;
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); s8 = 1'($urandom);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (glitch) begin iv8 = 1'($urandom); a8 = 8'($urandom); end
      @(negedge clk);
      if (ov8 === 1'b1) lat = n;
      else if (ir8 !== 1'b0 || b8 !== 1'b1) anom++;
    end
    iv8 = 1'b0;
    pr = p8;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b1 || p8 !== pr || ir8 !== 1'b0 || b8 !== 1'b1) anom++;
    end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || b8 !== 1'b0 || p8 !== pr) anom++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; s4 = 1'b0; or4 = 1'b0;
    iv8 = 1'b0; a8 = '0; s8 = 1'b0; or8 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ir4, ov4, b4, ir8, ov8, b8} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", {ir4, ov4, b4, ir8, ov8, b8});
    end
    total++;
    if (p4 !== 8'h00 || p8 !== 16'h0000) begin
      bad++; $display("FAIL reset_p got p4=%h p8=%h want 0", p4, p8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ir4 !== 1'b1 || ir8 !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b%b want=11", ir4, ir8);
    end
  endtask

  task automatic test_w4_directed();
    logic [3:0] va [5] = '{4'hF, 4'h8, 4'hF, 4'h7, 4'h0};
    logic       vs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] ve [5] = '{8'hE1, 8'h40, 8'h01, 8'h31, 8'h00};
    logic [7:0] pr;
    int lat, anom;
    for (int i = 0; i < 5; i++) begin
      drive4(va[i], vs[i], 0, 1'b0, pr, lat, anom);
      total++;
      if (pr !== ve[i]) begin
        bad++; $display("FAIL w4_dir_p a=%h sgn=%0d got=%h want=%h", va[i], vs[i], pr, ve[i]);
      end
      total++;
      if (lat !== 4 || anom !== 0) begin
        bad++; $display("FAIL w4_dir_proto a=%h got lat=%0d anom=%0d want lat=4 anom=0", va[i], lat, anom);
      end
    end
  endtask

  task automatic test_w4_exhaustive();
    logic [7:0] pr, ex;
    int lat, anom;
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 16; av++) begin
        drive4(4'(av), 1'(s), $urandom_range(0, 3), 1'b1, pr, lat, anom);
        ex = 8'(sq(longint'(av), 1'(s), 4));
        total++;
        if (pr !== ex) begin
          bad++; $display("FAIL w4_exh_p a=%h sgn=%0d got=%h want=%h", av, s, pr, ex);
        end
        total++;
        if (lat !== 4 || anom !== 0) begin
          bad++; $display("FAIL w4_exh_proto a=%h got lat=%0d anom=%0d want lat=4 anom=0", av, lat, anom);
        end
      end
    end
  endtask

  task automatic test_w8_directed();
    logic [7:0]  va [6];
    logic        vs [6];
    logic [15:0] pr, ex;
    int lat, anom;
    va[0] = 8'hFF; vs[0] = 1'b0;
    va[1] = 8'h80; vs[1] = 1'b1;
    for (int i = 2; i < 6; i++) begin va[i] = 8'($urandom); vs[i] = 1'($urandom); end
    for (int i = 0; i < 6; i++) begin
      drive8(va[i], vs[i], $urandom_range(0, 4), 1'b1, pr, lat, anom);
      ex = (i == 0) ? 16'hFE01 : (i == 1) ? 16'h4000 : 16'(sq(longint'(va[i]), vs[i], 8));
      total++;
      if (pr !== ex) begin
        bad++; $display("FAIL w8_p a=%h sgn=%0d got=%h want=%h", va[i], vs[i], pr, ex);
      end
      total++;
      if (lat !== 8 || anom !== 0) begin
        bad++; $display("FAIL w8_proto a=%h got lat=%0d anom=%0d want lat=8 anom=0", va[i], lat, anom);
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [15:0] pr;
    int lat, anom;
    // Reset with cnt = 2 in CALC.
    iv8 = 1'b1; a8 = 8'h55; s8 = 1'b0; or8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || b8 !== 1'b0 || ir8 !== 1'b0) begin
      bad++; $display("FAIL rst_calc got ov=%b p=%h busy=%b rdy=%b want 0,0000,0,0", ov8, p8, b8, ir8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      bad++; $display("FAIL rst_calc_release got rdy=%b ov=%b want 1,0", ir8, ov8);
    end
    // Reset while holding a result in DONE.
    iv8 = 1'b1; a8 = 8'h05; s8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (ov8 !== 1'b1 || p8 !== 16'd25) begin
      bad++; $display("FAIL done_before_rst got ov=%b p=%h want 1,0019", ov8, p8);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || b8 !== 1'b0) begin
      bad++; $display("FAIL rst_done got ov=%b p=%h busy=%b want 0,0000,0", ov8, p8, b8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    drive8(8'h03, 1'b0, 0, 1'b0, pr, lat, anom);
    total++;
    if (pr !== 16'h0009 || lat !== 8 || anom !== 0) begin
      bad++; $display("FAIL post_rst_txn got p=%h lat=%0d anom=%0d want 0009,8,0", pr, lat, anom);
    end
  endtask

  task automatic test_back_to_back();
    longint exq[$];
    int     acc_t[$];
    longint ex;
    iv8 = 1'b1; or8 = 1'b1; a8 = 8'($urandom); s8 = 1'($urandom);
    for (int c = 0; c <= 60; c++) begin
      if (ov8 === 1'b1) begin
        total++;
        if (exq.size() == 0) begin
          bad++; $display("FAIL b2b_extra got p=%h want no result", p8);
        end else begin
          ex = exq.pop_front();
          if (p8 !== 16'(ex)) begin
            bad++; $display("FAIL b2b_p got=%h want=%h", p8, 16'(ex));
          end
        end
      end
      if (ir8 === 1'b1) begin
        exq.push_back(sq(longint'(a8), s8, 8));
        acc_t.push_back(c);
      end
      @(negedge clk);
      a8 = 8'($urandom); s8 = 1'($urandom);
    end
    iv8 = 1'b0; or8 = 1'b0;
    total++;
    if (acc_t.size() != 7 || exq.size() != 1) begin
      bad++; $display("FAIL b2b_count got accepts=%0d pending=%0d want 7,1", acc_t.size(), exq.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      total++;
      if (acc_t[i] - acc_t[i-1] != 10) begin
        bad++; $display("FAIL b2b_spacing idx=%0d got=%0d want=10", i, acc_t[i] - acc_t[i-1]);
      end
    end
    // Drain the last accepted operand.
    or8 = 1'b1;
    for (int n = 0; n < 20 && ov8 !== 1'b1; n++) @(negedge clk);
    total++;
    if (ov8 !== 1'b1 || exq.size() == 0 || p8 !== 16'(exq[0])) begin
      bad++; $display("FAIL b2b_drain got ov=%b p=%h", ov8, p8);
    end
    @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w4_directed();
    test_w4_exhaustive();
    test_w8_directed();
    test_reset_inflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
